// File: rtl/vmem_pkg.sv
// Shared types and helpers for the vector memory serializer: FSM states,
// beat count and lane/address arithmetic for a 256-bit vector over 32-bit words.
package vmem_pkg;

  localparam int VLEN_P   = 256;
  localparam int WORD_W_P = 32;
  localparam int ADDR_W_P = 32;
  localparam int BEATS    = VLEN_P / WORD_W_P;
  localparam int LANE_W   = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [WORD_W_P-1:0] lane_select(
    input logic [VLEN_P-1:0] vec,
    input logic [LANE_W-1:0] lane
  );
    return vec[lane*WORD_W_P +: WORD_W_P];
  endfunction

  function automatic logic [VLEN_P-1:0] lane_write(
    input logic [VLEN_P-1:0]   vec,
    input logic [LANE_W-1:0]   lane,
    input logic [WORD_W_P-1:0] word
  );
    logic [VLEN_P-1:0] res;
    res = vec;
    res[lane*WORD_W_P +: WORD_W_P] = word;
    return res;
  endfunction

  // Byte address of a beat; the add is modulo 2^ADDR_W so bursts wrap past the top.
  function automatic logic [ADDR_W_P-1:0] beat_addr(
    input logic [ADDR_W_P-1:0] base,
    input logic [LANE_W-1:0]   beat
  );
    return base + ADDR_W_P'({beat, 2'b00});
  endfunction

endpackage

// File: rtl/vmem_lane_assembler.sv
// Wide assembly register written one word-lane at a time; clear zeroes all lanes.
module vmem_lane_assembler
  import vmem_pkg::*;
#(
  parameter int VLEN   = VLEN_P,
  parameter int WORD_W = WORD_W_P
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [LANE_W-1:0] lane,
  input  logic [WORD_W-1:0] wdata,
  output logic [VLEN-1:0]   data
);

  localparam int N = VLEN / WORD_W;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [WORD_W-1:0] word_reg;

      always_ff @(posedge clk) begin
        if (!rst || clear) begin
          word_reg <= '0;
        end else if (wr_en && (lane == LANE_W'(gi))) begin
          word_reg <= wdata;
        end
      end

      assign data[gi*WORD_W +: WORD_W] = word_reg;
    end
  endgenerate

endmodule

// File: rtl/vector_mem_serializer.sv
// Splits one 256-bit vector load/store into eight 32-bit RAM beats, reassembles
// load data, and stalls the Memory stage until the access completes.
module vector_mem_serializer
  import vmem_pkg::*;
#(
  parameter int VLEN    = VLEN_P,
  parameter int WORD_W  = WORD_W_P,
  parameter int ADDR_W  = ADDR_W_P,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [VLEN-1:0]   req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [VLEN-1:0]   rsp_rdata,
  output logic              stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata
);

  state_t              state_reg, state_next;
  logic                we_reg;
  logic [ADDR_W-1:0]   base_reg;
  logic [VLEN-1:0]     wdata_reg;
  logic [LANE_W-1:0]   issue_cnt_reg;
  logic [LANE_W-1:0]   cap_cnt_reg;
  logic [LANE_W-1:0]   next_beat;
  logic [RAM_LAT-1:0]  rd_pipe_reg;
  logic [VLEN-1:0]     asm_data;
  logic [ADDR_W-1:0]   aligned_addr;
  logic                accept;
  logic                last_issue;
  logic                rd_issue;
  logic                capture;
  logic                last_capture;
  logic                addr_lsb_unused;

  assign addr_lsb_unused = ^req_addr[1:0];
  assign aligned_addr    = {req_addr[ADDR_W-1:2], 2'b00};
  assign accept          = (state_reg == IDLE) && req_valid;
  assign next_beat       = issue_cnt_reg + LANE_W'(1);
  assign last_issue      = (issue_cnt_reg == LANE_W'(BEATS - 1));
  assign rd_issue        = ram_en && !ram_we;
  assign capture         = rd_pipe_reg[RAM_LAT-1];
  assign last_capture    = capture && (cap_cnt_reg == LANE_W'(BEATS - 1));

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == DONE);
  assign stall     = ((state_reg != IDLE) && (state_reg != DONE)) ||
                     ((state_reg == IDLE) && req_valid);

  // Marks which cycles carry a returning read word, RAM_LAT cycles after issue.
  generate
    if (RAM_LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (!rst) rd_pipe_reg <= '0;
        else      rd_pipe_reg <= rd_issue;
      end
    end else begin : g_latn
      always_ff @(posedge clk) begin
        if (!rst) rd_pipe_reg <= '0;
        else      rd_pipe_reg <= {rd_pipe_reg[RAM_LAT-2:0], rd_issue};
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = req_we ? WRITE : READ;
      WRITE:   if (last_issue) state_next = DONE;
      READ:    if (last_issue) state_next = DRAIN;
      DRAIN:   if (last_capture) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      base_reg      <= '0;
      wdata_reg     <= '0;
      issue_cnt_reg <= '0;
      cap_cnt_reg   <= '0;
      ram_en        <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      rsp_rdata     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg        <= req_we;
            base_reg      <= aligned_addr;
            wdata_reg     <= req_wdata;
            issue_cnt_reg <= '0;
            cap_cnt_reg   <= '0;
            ram_en        <= 1'b1;
            ram_we        <= req_we;
            ram_addr      <= aligned_addr;
            ram_wdata     <= req_we ? lane_select(req_wdata, LANE_W'(0)) : '0;
          end
        end
        WRITE, READ: begin
          if (last_issue) begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
          end else begin
            issue_cnt_reg <= next_beat;
            ram_addr      <= beat_addr(base_reg, next_beat);
            ram_wdata     <= we_reg ? lane_select(wdata_reg, next_beat) : '0;
          end
        end
        default: ;
      endcase

      if (capture) cap_cnt_reg <= cap_cnt_reg + LANE_W'(1);
      // Merge the final word directly so the response is complete in the DONE cycle.
      if (last_capture) rsp_rdata <= lane_write(asm_data, cap_cnt_reg, ram_rdata);
    end
  end

  vmem_lane_assembler #(
    .VLEN   (VLEN),
    .WORD_W (WORD_W)
  ) u_assembler (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .wr_en (capture),
    .lane  (cap_cnt_reg),
    .wdata (ram_rdata),
    .data  (asm_data)
  );

endmodule

// File: tb/tb_vector_mem_serializer.sv
// Directed bench: dut_a runs with a 1-cycle RAM, dut_b with a 2-cycle address-derived RAM.
module tb_vector_mem_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req_valid_a, req_we_a, req_ready_a, rsp_valid_a, stall_a;
  logic         ram_en_a, ram_we_a;
  logic [31:0]  req_addr_a, ram_addr_a, ram_wdata_a, ram_rdata_a;
  logic [255:0] req_wdata_a, rsp_rdata_a;
  logic         req_valid_b, req_we_b, req_ready_b, rsp_valid_b, stall_b;
  logic         ram_en_b, ram_we_b;
  logic [31:0]  req_addr_b, ram_addr_b, ram_wdata_b, ram_rdata_b;
  logic [255:0] req_wdata_b, rsp_rdata_b;

  int checks = 0;
  int errors = 0;

  vector_mem_serializer #(.RAM_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_we(req_we_a), .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .req_ready(req_ready_a), .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .stall(stall_a),
    .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
    .ram_rdata(ram_rdata_a)
  );

  vector_mem_serializer #(.RAM_LAT(2)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_we(req_we_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .req_ready(req_ready_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .stall(stall_b),
    .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
    .ram_rdata(ram_rdata_b)
  );

  // RAM models: A is a real 256-word memory, B returns address + 0xB0000000.
  logic [31:0] mem_a [256];
  logic [31:0] rdq_a, rdq1_b, rdq2_b;
  always @(posedge clk) begin
    if (ram_en_a && ram_we_a)  mem_a[ram_addr_a[9:2]] <= ram_wdata_a;
    if (ram_en_a && !ram_we_a) rdq_a <= mem_a[ram_addr_a[9:2]];
    if (ram_en_b && !ram_we_b) rdq1_b <= ram_addr_b + 32'hB000_0000;
    rdq2_b <= rdq1_b;
  end
  assign ram_rdata_a = rdq_a;
  assign ram_rdata_b = rdq2_b;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Store on dut_a: accept cycle, eight beats, DONE, back to IDLE.
  task automatic store_a(input string tag, input logic [31:0] addr, input logic [31:0] base,
                         input logic [255:0] data, input logic [255:0] rd_exp);
    @(negedge clk);
    req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = addr; req_wdata_a = data;
    #1;
    chk({tag, "_accept"}, {req_ready_a, stall_a}, 2'b11);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid_a = 1'b0;
      #1;
      chk({tag, "_beat"}, {ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a, stall_a, rsp_valid_a, req_ready_a},
          {1'b1, 1'b1, base + 32'(4 * i), data[32*i +: 32], 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk); #1;
    chk({tag, "_done"}, {rsp_valid_a, stall_a, ram_en_a, req_ready_a, rsp_rdata_a},
        {1'b1, 1'b0, 1'b0, 1'b0, rd_exp});
    @(negedge clk); #1;
    chk({tag, "_idle"}, {rsp_valid_a, req_ready_a, stall_a}, 3'b010);
  endtask

  // Load on dut_a (RAM_LAT = 1): issues T+1..T+8, DONE at T+10, data held at T+11.
  task automatic load_a(input string tag, input logic [31:0] addr, input logic [31:0] base,
                        input logic [255:0] exp);
    @(negedge clk);
    req_valid_a = 1'b1; req_we_a = 1'b0; req_addr_a = addr;
    #1;
    chk({tag, "_accept"}, {req_ready_a, stall_a}, 2'b11);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid_a = 1'b0;
      #1;
      chk({tag, "_issue"}, {ram_en_a, ram_we_a, ram_addr_a, stall_a, rsp_valid_a},
          {1'b1, 1'b0, base + 32'(4 * i), 1'b1, 1'b0});
    end
    @(negedge clk); #1;
    chk({tag, "_drain"}, {rsp_valid_a, ram_en_a, stall_a}, 3'b001);
    @(negedge clk); #1;
    chk({tag, "_done"}, {rsp_valid_a, stall_a, rsp_rdata_a}, {1'b1, 1'b0, exp});
    @(negedge clk); #1;
    chk({tag, "_hold"}, {rsp_valid_a, req_ready_a, rsp_rdata_a}, {1'b0, 1'b1, exp});
  endtask

  initial begin
    logic [255:0] vec, vec2, vec_b;
    for (int i = 0; i < 8; i++) begin
      vec[32*i +: 32]   = 32'(i + 1) * 32'h1111_1111;
      vec2[32*i +: 32]  = 32'hA000_0000 + 32'(i);
      vec_b[32*i +: 32] = 32'hB000_0100 + 32'(4 * i);
    end
    rst = 1'b0;
    req_valid_a = 1'b0; req_we_a = 1'b0; req_addr_a = '0; req_wdata_a = '0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_a", {req_ready_a, rsp_valid_a, stall_a, ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a, rsp_rdata_a},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 256'h0});
    chk("reset_b", {req_ready_b, rsp_valid_b, ram_en_b, rsp_rdata_b}, {1'b1, 1'b0, 1'b0, 256'h0});
    @(negedge clk);
    rst = 1'b1;

    store_a("st100", 32'h0000_0100, 32'h0000_0100, vec, 256'h0);
    load_a("ld100", 32'h0000_0100, 32'h0000_0100, vec);
    store_a("stwrap", 32'hFFFF_FFF0, 32'hFFFF_FFF0, vec2, vec);
    load_a("ld103", 32'h0000_0103, 32'h0000_0100, vec);

    // Reset asserted at edge T+4 of a load
    @(negedge clk);
    req_valid_a = 1'b1; req_we_a = 1'b0; req_addr_a = 32'h0000_0100;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid_a = 1'b0;
      #1;
      chk("rst_pre", {ram_en_a, ram_addr_a}, {1'b1, 32'h100 + 32'(4 * i)});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_edge", {ram_en_a, ram_addr_a}, {1'b1, 32'h0000_010C});
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_after", {ram_en_a, rsp_valid_a, req_ready_a, stall_a, rsp_rdata_a},
        {1'b0, 1'b0, 1'b1, 1'b0, 256'h0});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      chk("rst_quiet", {ram_en_a, rsp_valid_a, rsp_rdata_a}, {1'b0, 1'b0, 256'h0});
    end

    // dut_b, RAM_LAT = 2: load then store with req_valid held high
    @(negedge clk);
    req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = 32'h0000_0100;
    #1;
    chk("b2b_accept", {req_ready_b, stall_b}, 2'b11);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_we_b = 1'b1; req_addr_b = 32'h0000_0200; req_wdata_b = vec;
      end
      #1;
      chk("b2b_busy", {req_ready_b, stall_b, rsp_valid_b}, 3'b010);
    end
    @(negedge clk); #1;
    chk("b2b_ld_done", {rsp_valid_b, stall_b, req_ready_b, rsp_rdata_b}, {1'b1, 1'b0, 1'b0, vec_b});
    @(negedge clk); #1;
    chk("b2b_idle", {req_ready_b, stall_b, rsp_valid_b}, 3'b110);
    @(negedge clk);
    req_valid_b = 1'b0;
    #1;
    chk("b2b_st_beat0", {ram_en_b, ram_we_b, ram_addr_b, ram_wdata_b},
        {1'b1, 1'b1, 32'h0000_0200, vec[31:0]});
    repeat (7) @(negedge clk);
    @(negedge clk); #1;
    chk("b2b_st_done", {rsp_valid_b, rsp_rdata_b}, {1'b1, vec_b});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_mem_serializer.md
Name: vector_mem_serializer

Overview:
Multi-cycle data-memory front end placed directly downstream of the pipeline's Memory stage. It converts one 256-bit vector load or store into a burst of eight 32-bit word accesses on a narrow single-port data RAM. It reassembles load data into a 256-bit response and asserts stall to the pipeline until the vector access completes.

Parameters:
VLEN, 256, vector width in bits; must equal an integer multiple of WORD_W
WORD_W, 32, RAM word width in bits
ADDR_W, 32, byte address width
RAM_LAT, 1, RAM read latency in cycles from ram_en to ram_rdata valid; legal values are 1 and 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
req_valid  in  1  Memory stage presents a vector access
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte base address; bits [1:0] are ignored and forced to 0
req_wdata  in  VLEN  store data
req_ready  out  1  block can accept a request this cycle
rsp_valid  out  1  one-cycle pulse; access complete
rsp_rdata  out  VLEN  assembled load data
stall  out  1  holds the pipeline Memory stage
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM byte address
ram_wdata  out  WORD_W  RAM write word
ram_rdata  in  WORD_W  RAM read word, valid RAM_LAT cycles after ram_en with ram_we = 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low: rst = 0 at a rising clk edge resets all state.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, ram_en 0, ram_we 0, ram_addr 0, ram_wdata 0, all counters 0.
- BEATS = VLEN/WORD_W = 8. Beat i carries vector bits [32i+31:32i]; lane 0 is the least-significant lane.
- Address of beat i = base + 4*i, computed modulo 2^ADDR_W, so a burst that crosses 0xFFFFFFFC wraps to 0x00000000.
- States:
  - IDLE: req_ready = 1. When req_valid = 1, latch req_we, the aligned base address and req_wdata, then go to WRITE or READ. In all other states req_ready = 0, and req_valid is ignored.
  - WRITE: registered outputs ram_en = 1, ram_we = 1, ram_addr = beat address, ram_wdata = lane i; one beat per cycle. After beat 7, go to DONE.
  - READ: ram_en = 1, ram_we = 0; one address per cycle, beats 0..7. After issuing beat 7, go to DRAIN.
  - DRAIN: ram_en = 0. Capture returning words by capture counter. When the capture counter reaches 8, go to DONE.
  - DONE: rsp_valid = 1 for exactly one cycle, then go to IDLE.
- Read capture: the word returned for beat i, arriving RAM_LAT cycles after its issue, is written into lane i of an internal assembly register. Capture also runs during READ, overlapping issue.
- rsp_rdata updates only on load completion and is stable from the DONE cycle until the next load completes. A store leaves rsp_rdata unchanged.
- Latency, with request accepted at edge T:
  - Store: beats on cycles T+1..T+8; rsp_valid on cycle T+9.
  - Load: issues on cycles T+1..T+8; rsp_valid on cycle T+9+RAM_LAT.
- stall (combinational) = (state not in {IDLE, DONE}) OR (state == IDLE AND req_valid). stall is 0 in the DONE cycle, so the pipeline advances together with rsp_valid.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE; there is no acceptance in DONE.
- Reset mid-operation: on the reset edge, ram_en goes to 0, no further beats are issued, partial load data is discarded, rsp_valid is not produced, and rsp_rdata returns to 0.
- ram_rdata is ignored when no capture is pending.

Decomposition:
- Shared package vmem_pkg: state enumeration (IDLE, WRITE, READ, DRAIN, DONE), BEATS constant, lane-select function, beat-address function with wrap.
- One sub-module, vmem_lane_assembler: a 256-bit register with 3-bit lane index write enable and a clear input. It is used for read capture.

Test Plan:
- Store at 0x100 with lanes 0x11111111..0x88888888 -> ram_addr 0x100, 0x104, …, 0x11C with ram_we = 1 on cycles T+1..T+8, in that word order; rsp_valid at T+9; stall high T..T+8.
- Load at 0x100 after that store, with a RAM_LAT = 1 model -> rsp_valid at T+10; rsp_rdata = {0x88888888, …, 0x11111111}.
- Store at 0xFFFFFFF0 -> addresses 0xFFFFFFF0, 0xFFFFFFF4, 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, 0x8, 0xC.
- req_addr = 0x103 -> beat addresses start at 0x100.
- rst = 0 at T+4 of a load -> ram_en = 0 from the next cycle, no rsp_valid pulse, rsp_rdata = 0, req_ready = 1.
- req_valid held high across two requests, with RAM_LAT = 2 and a load then a store -> second request accepted the cycle after rsp_valid; load rsp_valid at T+11.
